// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int unsigned OVS       = 16;
  localparam int unsigned START_MID = 8;
  localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every BAUD_DIV clocks, held at zero by clr_i.
module uart_baud_tick #(
  parameter int unsigned BAUD_DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [11:0] LAST = 12'(BAUD_DIV - 1);

  logic [11:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Next count: synchronous clear, otherwise wrap at BAUD_DIV-1.
  always_comb begin
    cnt_d = cnt_q + 12'd1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver with valid/ready output and error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [3:0] START_LAST = 4'(START_MID - 1);
  localparam logic [3:0] SMP_LAST   = 4'(OVS - 1);
  localparam logic [2:0] BIT_LAST   = 3'(DATA_BITS - 1);

  logic       rx_meta_q, rx_s_q;
  rx_state_t  state_q, state_d;
  logic [3:0] smp_q, smp_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;
  logic       tick;
  logic       stop_tick;
  logic       good;
  logic       load;

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i ((state_q == IDLE) || !ena),
    .tick_o(tick)
  );

  // Two-flop synchronizer for the asynchronous serial line (idle high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame FSM: start validation at mid start bit, then one sample per bit centre.
  always_comb begin
    state_d   = state_q;
    smp_d     = smp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    stop_tick = 1'b0;
    case (state_q)
      IDLE: begin
        smp_d = '0;
        bit_d = '0;
        if (ena && !rx_s_q) state_d = START;
      end
      START: if (tick) begin
        if (smp_q == START_LAST) begin
          smp_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          smp_d = smp_q + 4'd1;
        end
      end
      DATA: if (tick) begin
        if (smp_q == SMP_LAST) begin
          smp_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) state_d = STOP;
        end else begin
          smp_d = smp_q + 4'd1;
        end
      end
      STOP: if (tick) begin
        if (smp_q == SMP_LAST) begin
          smp_d     = '0;
          stop_tick = 1'b1;
          state_d   = IDLE;
        end else begin
          smp_d = smp_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Disabling abandons the frame outright, including a stop sample on this edge.
    if (!ena) begin
      state_d   = IDLE;
      smp_d     = '0;
      bit_d     = '0;
      stop_tick = 1'b0;
    end
  end

  // Holding register and status pulses; a same-edge load and consume keeps the new byte.
  always_comb begin
    good    = stop_tick && rx_s_q;
    load    = good && (!valid_q || rx_ready);
    ferr_d  = stop_tick && !rx_s_q;
    ovr_d   = good && valid_q && !rx_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = shift_q;
    end else if (rx_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      smp_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIV=4 (64 clocks per bit).
module tb_uart_rx;

  localparam int unsigned BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int cyc      = 0;
  int t_fall   = 0;
  int rise_cyc = 0;
  int rise_cnt = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int busy_cnt = 0;
  int vlow_cnt = 0;
  logic prev_vld = 1'b0;

  int b_rise, b_fe, b_ov, b_busy, b_vlow;
  int lat;

  uart_rx #(
    .BAUD_DIV(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event counters sampled mid-cycle; tests compare deltas around each scenario.
  always @(negedge clk) begin
    if (rx_valid && !prev_vld) begin
      rise_cyc <= cyc;
      rise_cnt <= rise_cnt + 1;
    end
    prev_vld <= rx_valid;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
    if (busy)      busy_cnt <= busy_cnt + 1;
    if (!rx_valid) vlow_cnt <= vlow_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    t_fall = cyc;
    rx = 1'b0;
    wait_cycles(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(BIT_CLKS);
    end
    rx = stop;
    wait_cycles(BIT_CLKS);
    rx = 1'b1;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    wait_cycles(1);
    rx_ready = 1'b0;
    wait_cycles(1);
  endtask

  task automatic snap();
    b_rise = rise_cnt;
    b_fe   = fe_cnt;
    b_ov   = ov_cnt;
    b_busy = busy_cnt;
    b_vlow = vlow_cnt;
  endtask

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b1;
    rx       = 1'b1;
    rx_ready = 1'b0;
    wait_cycles(5);
    check("reset_outputs", {rx_data, rx_valid, frame_err, overrun, busy}, 32'h0);
    rst_n = 1'b1;
    wait_cycles(10);

    // Reset asserted in the middle of a frame, then a clean 0x3C.
    rx = 1'b0;
    wait_cycles(200);
    check("busy_mid_frame", busy, 1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_frame_outputs", {rx_data, rx_valid, frame_err, overrun, busy}, 32'h0);
    rx = 1'b1;
    wait_cycles(4);
    rst_n = 1'b1;
    wait_cycles(4);
    check("busy_after_reset", busy, 0);
    snap();
    send_frame(8'h3C, 1'b1);
    check("data_3c", rx_data, 32'h3C);
    check("valid_3c", rx_valid, 1);
    consume();
    check("valid_cleared", rx_valid, 0);

    // Single byte latency.
    wait_cycles(10);
    snap();
    send_frame(8'hA5, 1'b1);
    lat = rise_cyc - t_fall;
    check("data_a5", rx_data, 32'hA5);
    check("valid_a5", rx_valid, 1);
    check("latency_611pm1", (lat >= 610 && lat <= 612), 1);
    check("no_ferr_a5", fe_cnt - b_fe, 0);
    consume();

    // Short low glitch is rejected at mid start bit.
    wait_cycles(10);
    snap();
    rx = 1'b0;
    wait_cycles(20);
    rx = 1'b1;
    wait_cycles(60);
    check("glitch_busy_cycles", busy_cnt - b_busy, 32);
    check("glitch_busy_end", busy, 0);
    check("glitch_no_valid", rise_cnt - b_rise, 0);
    check("glitch_no_flags", (fe_cnt - b_fe) + (ov_cnt - b_ov), 0);

    // Framing error: stop bit low.
    snap();
    send_frame(8'h55, 1'b0);
    wait_cycles(100);
    check("ferr_pulses", fe_cnt - b_fe, 1);
    check("ferr_no_valid", rx_valid, 0);
    check("ferr_no_ovr", ov_cnt - b_ov, 0);
    check("ferr_idle", busy, 0);

    // Overrun: two frames back-to-back without consuming.
    snap();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_cycles(2);
    check("ovr_data_held", rx_data, 32'h11);
    check("ovr_valid", rx_valid, 1);
    check("ovr_pulses", ov_cnt - b_ov, 1);
    check("ovr_valid_rises", rise_cnt - b_rise, 1);

    // Consume on the exact load edge: new byte replaces old, no gap, no overrun.
    snap();
    fork
      send_frame(8'h33, 1'b1);
      begin
        wait_cycles(610);
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
      end
    join
    check("same_edge_data", rx_data, 32'h33);
    check("same_edge_valid", rx_valid, 1);
    check("same_edge_no_ovr", ov_cnt - b_ov, 0);
    check("same_edge_no_gap", vlow_cnt - b_vlow, 0);
    consume();

    // Enable dropped mid-byte.
    wait_cycles(10);
    snap();
    fork
      send_frame(8'hC3, 1'b1);
      begin
        wait_cycles(300);
        ena = 1'b0;
        wait_cycles(1);
        check("ena_low_busy", busy, 0);
      end
    join
    wait_cycles(10);
    check("ena_no_valid", rise_cnt - b_rise, 0);
    check("ena_no_flags", (fe_cnt - b_fe) + (ov_cnt - b_ov), 0);
    ena = 1'b1;
    wait_cycles(10);
    send_frame(8'hFF, 1'b1);
    check("data_ff", rx_data, 32'hFF);
    check("valid_ff", rx_valid, 1);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
